// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first, behind a start/busy/done handshake.
// Define OVERFLOW_FLAG_EN to add the registered two's-complement overflow output ovf.
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic br_next;
    logic accept;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        idx_d   = idx_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d   = ovf_q;
`endif
        accept  = 1'b0;

        a_bit   = a_q[idx_q];
        b_bit   = b_q[idx_q];
        d_bit   = a_bit ^ b_bit ^ br_q;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                end
            end
            ST_SHIFT: begin
                diff_d[idx_q] = d_bit;
                br_d          = br_next;
                idx_d         = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    bout_d  = br_next;
`ifdef OVERFLOW_FLAG_EN
                    // d_bit is the final sign bit of the difference at this point.
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_bit != a_q[WIDTH-1]);
`endif
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    accept = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = b;
            br_d    = bin;
            idx_d   = '0;
            diff_d  = '0;
            bout_d  = 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_d   = 1'b0;
`endif
            state_d = ST_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            idx_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            idx_q   <= idx_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Every output is decoded from registered state only.
    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed self-checking bench for serial_subtractor_4bit (WIDTH=4); inputs change and outputs are sampled on the falling edge.
// Checks ovf as well when OVERFLOW_FLAG_EN is defined.
module tb_serial_subtractor_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;
`ifdef OVERFLOW_FLAG_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Launches one operation and waits (bounded) for done; returns at the falling edge where done is seen.
    task automatic do_op(input logic [3:0] ai, input logic [3:0] bi, input logic bni,
                         output bit got, output int lat);
        @(negedge clk);
        a = ai; b = bi; bin = bni; start = 1'b1;
        got = 1'b0; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; a = 4'hF; b = 4'h1; bin = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (diff !== 4'h0) begin errors++; $display("[TB] FAIL reset_diff: got %h expected 0", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("[TB] FAIL reset_bout: got %b expected 0", bout); end
`ifdef OVERFLOW_FLAG_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic;
        logic [1:0] exp_bd;
        @(negedge clk);
        a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            exp_bd = (k <= 4) ? 2'b10 : 2'b01;
            checks++;
            if ({busy, done} !== exp_bd) begin
                errors++;
                $display("[TB] FAIL basic_cycle%0d {busy,done}: got %b expected %b", k, {busy, done}, exp_bd);
            end
        end
        checks++; if (diff !== 4'b0010) begin errors++; $display("[TB] FAIL basic_diff: got %b expected 0010", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("[TB] FAIL basic_bout: got %b expected 0", bout); end
`ifdef OVERFLOW_FLAG_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b expected 0", ovf); end
`endif
    endtask

    task automatic test_borrow;
        logic [3:0] ta [3] = '{4'b0011, 4'b0000, 4'b1111};
        logic [3:0] tb [3] = '{4'b0101, 4'b0000, 4'b1111};
        logic       tn [3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] td [3] = '{4'b1110, 4'b1111, 4'b1111};
        bit got;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], tn[i], got, lat);
            checks++; if (!got) begin errors++; $display("[TB] FAIL borrow%0d_timeout: got no done expected done", i); end
            checks++; if (diff !== td[i]) begin errors++; $display("[TB] FAIL borrow%0d_diff: got %b expected %b", i, diff, td[i]); end
            checks++; if (bout !== 1'b1) begin errors++; $display("[TB] FAIL borrow%0d_bout: got %b expected 1", i, bout); end
        end
    endtask

    task automatic test_start_held;
        int dones = 0;
        @(negedge clk);
        a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin a = 4'b1001; b = 4'b0001; bin = 1'b1; end
            if (k == 4) start = 1'b0;
            if (done) dones++;
        end
        checks++; if (dones != 1) begin errors++; $display("[TB] FAIL held_done_count: got %0d expected 1", dones); end
        checks++; if (diff !== 4'b0010) begin errors++; $display("[TB] FAIL held_diff: got %b expected 0010", diff); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        bit got;
        int lat;
        do_op(4'd6, 4'd2, 1'b0, got, lat);
        checks++; if (!got) begin errors++; $display("[TB] FAIL b2b_first_timeout: got no done expected done"); end
        checks++; if (diff !== 4'd4) begin errors++; $display("[TB] FAIL b2b_first_diff: got %h expected 4", diff); end
        a = 4'd2; b = 4'd7; bin = 1'b1; start = 1'b1;
        got = 1'b0; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) begin got = 1'b1; lat = k; break; end
        end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 5", lat); end
        checks++; if (diff !== 4'b1010) begin errors++; $display("[TB] FAIL b2b_diff: got %b expected 1010", diff); end
        checks++; if (bout !== 1'b1) begin errors++; $display("[TB] FAIL b2b_bout: got %b expected 1", bout); end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        @(negedge clk);
        a = 4'b1001; b = 4'b0100; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done: got %b expected 0", done); end
        checks++; if (diff !== 4'b0000) begin errors++; $display("[TB] FAIL mid_diff: got %b expected 0000", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("[TB] FAIL mid_bout: got %b expected 0", bout); end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("[TB] FAIL mid_no_done: got %0d expected 0", dones); end
    endtask

    task automatic test_exhaustive;
        logic [3:0] ai;
        logic [3:0] bi;
        logic       ni;
        logic [4:0] exp5;
        logic [4:0] got5;
        bit got;
        int lat;
        for (int i = 0; i < 512; i++) begin
            ai = i[8:5]; bi = i[4:1]; ni = i[0];
            exp5 = {1'b0, ai} - {1'b0, bi} - {4'b0000, ni};
            do_op(ai, bi, ni, got, lat);
            got5 = {bout, diff};
            checks++;
            if (!got || got5 !== exp5) begin
                errors++;
                $display("[TB] FAIL exh a=%h b=%h bin=%b: got done=%b {bout,diff}=%b expected %b", ai, bi, ni, got, got5, exp5);
            end
`ifdef OVERFLOW_FLAG_EN
            checks++;
            if (ovf !== ((ai[3] != bi[3]) && (exp5[3] != ai[3]))) begin
                errors++;
                $display("[TB] FAIL exh_ovf a=%h b=%h bin=%b: got %b expected %b", ai, bi, ni, ovf, (ai[3] != bi[3]) && (exp5[3] != ai[3]));
            end
`endif
            @(negedge clk);
            checks++;
            if ({bout, diff} !== exp5) begin
                errors++;
                $display("[TB] FAIL exh_hold a=%h b=%h bin=%b: got %b expected %b", ai, bi, ni, {bout, diff}, exp5);
            end
        end
    endtask

`ifdef OVERFLOW_FLAG_EN
    task automatic test_overflow;
        logic [3:0] ta [3] = '{4'b1000, 4'b0111, 4'b0101};
        logic [3:0] tb [3] = '{4'b0001, 4'b1111, 4'b0011};
        logic [3:0] td [3] = '{4'b0111, 4'b1000, 4'b0010};
        logic       to [3] = '{1'b1, 1'b1, 1'b0};
        bit got;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], 1'b0, got, lat);
            checks++; if (!got || diff !== td[i]) begin errors++; $display("[TB] FAIL ovf%0d_diff: got %b expected %b", i, diff, td[i]); end
            checks++; if (ovf !== to[i]) begin errors++; $display("[TB] FAIL ovf%0d_flag: got %b expected %b", i, ovf, to[i]); end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
`ifdef OVERFLOW_FLAG_EN
        test_overflow();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
